// File: rtl/slow_clock_monitor_pkg.sv
// Shared types and constants for the slow-clock receive monitor.
package slow_clock_monitor_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} mon_state_t;

  localparam int unsigned LOCK_COUNT = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history
// flop that yields a one-cycle rising-edge strobe in the destination domain.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_hist;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_edge_detect: STAGES must be at least 2");
  end

endmodule

// File: rtl/slow_clock_monitor.sv
// Receives the divided slow clock: synchronises it, ticks once per rising
// edge, measures each period and tracks lock / loss-of-clock.
//   state   | meaning
//   IDLE    | no edge seen since reset
//   MEASURE | edges arriving, fewer than LOCK_COUNT consecutive good periods
//   LOCKED  | period has been within tolerance long enough
//   LOST    | no edge within NOMINAL_PERIOD+TOLERANCE cycles
module slow_clock_monitor
  import slow_clock_monitor_pkg::*;
#(
  parameter int unsigned NOMINAL_PERIOD = 50_000_000,
  parameter int unsigned TOLERANCE      = 500_000,
  parameter int unsigned CNT_W          = 28,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             slow_clk_in,
  output logic             tick_out,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [63:0] LP_LIMIT   = 64'(NOMINAL_PERIOD) + 64'(TOLERANCE);
  localparam logic [63:0] LP_CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W:0] LP_HI   = (CNT_W+1)'(LP_LIMIT);
  localparam logic [CNT_W:0] LP_LO   = (NOMINAL_PERIOD > TOLERANCE) ?
                                       (CNT_W+1)'(NOMINAL_PERIOD - TOLERANCE) : '0;
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(LP_LIMIT);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  if (LP_LIMIT > LP_CNT_MAX) begin : g_bad_width
    $error("slow_clock_monitor: CNT_W too narrow for NOMINAL_PERIOD+TOLERANCE");
  end

  logic             w_rise;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W:0]   w_period_ext;
  logic             w_in_tol;
  logic             w_timeout;

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_good_cnt;
  logic             r_tick;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_lost;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_async (slow_clk_in),
    .o_rise  (w_rise)
  );

  // The rise cycle itself is the last cycle of the period, hence cnt+1.
  assign w_cnt_sat    = &r_cnt;
  assign w_period     = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign w_period_ext = {1'b0, w_period};
  assign w_in_tol     = (w_period_ext >= LP_LO) && (w_period_ext <= LP_HI);
  assign w_timeout    = (r_cnt == LP_TIMEOUT) && !w_rise;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_good_cnt     <= '0;
      r_tick         <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_lost         <= 1'b0;
    end else begin
      r_tick         <= w_rise;
      r_period_valid <= 1'b0;

      if (w_rise) begin
        r_cnt <= '0;
      end else if (!w_cnt_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEASURE;
          end
        end

        MEASURE: begin
          if (w_rise) begin
            r_period       <= w_period;
            r_period_valid <= 1'b1;
            if (w_in_tol) begin
              if (r_good_cnt >= GW'(LOCK_COUNT - 1)) begin
                r_good_cnt <= GW'(LOCK_COUNT);
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
              end else begin
                r_good_cnt <= r_good_cnt + GW'(1);
              end
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state  <= LOST;
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
          end
        end

        LOCKED: begin
          if (w_rise) begin
            r_period       <= w_period;
            r_period_valid <= 1'b1;
            if (!w_in_tol) begin
              r_state    <= MEASURE;
              r_locked   <= 1'b0;
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state  <= LOST;
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
          end
        end

        LOST: begin
          // The interval spanning the outage is meaningless, so no measurement.
          if (w_rise) begin
            r_state    <= MEASURE;
            r_lost     <= 1'b0;
            r_good_cnt <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tick_out     = r_tick;
  assign period_out   = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign lost         = r_lost;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor at NOMINAL_PERIOD=8, TOLERANCE=1.
module tb_slow_clock_monitor;

  localparam int unsigned CNT_W = 8;

  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             slow_clk_in;
  logic             tick_out;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             lost;

  int n_checks      = 0;
  int n_errors      = 0;
  int cyc           = 0;
  int tick_cnt      = 0;
  int last_tick_cyc = -100;
  int pv_cnt        = 0;
  int pv_period     = 0;
  int pv_locked     = 0;
  int rise_cyc      = 0;
  int waited        = 0;

  slow_clock_monitor #(
    .NOMINAL_PERIOD (8),
    .TOLERANCE      (1),
    .CNT_W          (CNT_W),
    .SYNC_STAGES    (2)
  ) u_dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .slow_clk_in  (slow_clk_in),
    .tick_out     (tick_out),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc++;

  always @(negedge clock_in) begin
    if (tick_out === 1'b1) begin
      tick_cnt++;
      last_tick_cyc = cyc;
    end
    if (period_valid === 1'b1) begin
      pv_cnt++;
      pv_period = int'(period_out);
      pv_locked = int'(locked);
    end
  end

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1; rises of consecutive calls are hi+lo cycles apart.
  task automatic drive_period(input int hi, input int lo);
    slow_clk_in = 1'b1;
    rise_cyc    = cyc;
    repeat (hi) begin @(posedge clock_in); #1; end
    slow_clk_in = 1'b0;
    repeat (lo) begin @(posedge clock_in); #1; end
  endtask

  task automatic chk_pv(input string tag, input int cnt, input int per, input int lck);
    chk_val({tag, "_pv_cnt"}, pv_cnt, cnt);
    chk_val({tag, "_period"}, pv_period, per);
    chk_val({tag, "_locked"}, pv_locked, lck);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    slow_clk_in = 1'b0;
    repeat (6) begin @(posedge clock_in); #1; slow_clk_in = ~slow_clk_in; end
    @(negedge clock_in);
    chk_val("rst_tick",   int'(tick_out), 0);
    chk_val("rst_period", int'(period_out), 0);
    chk_val("rst_pv",     int'(period_valid), 0);
    chk_val("rst_locked", int'(locked), 0);
    chk_val("rst_lost",   int'(lost), 0);

    @(posedge clock_in); #1;
    reset_n = 1'b1;
    repeat (20) begin @(posedge clock_in); #1; end
    chk_val("idle_ticks", tick_cnt, 0);
    chk_val("idle_pv",    pv_cnt, 0);
    chk_val("idle_lost",  int'(lost), 0);
    chk_val("idle_lock",  int'(locked), 0);

    drive_period(4, 4);
    chk_val("r1_tick_lat", last_tick_cyc - rise_cyc, 3);
    chk_val("r1_ticks",    tick_cnt, 1);
    chk_val("r1_no_pv",    pv_cnt, 0);
    drive_period(4, 4);
    chk_pv("r2", 1, 8, 0);
    drive_period(6, 4);
    chk_pv("r3", 2, 8, 1);
    chk_val("r3_locked_lvl", int'(locked), 1);
    drive_period(4, 4);
    chk_pv("r4_p10", 3, 10, 0);
    chk_val("r4_no_lost", int'(lost), 0);
    drive_period(4, 3);
    chk_pv("r5", 4, 8, 0);
    drive_period(4, 5);
    chk_pv("r6_p7", 5, 7, 1);
    drive_period(3, 3);
    chk_pv("r7_p9", 6, 9, 1);
    drive_period(4, 4);
    chk_pv("r8_p6", 7, 6, 0);
    drive_period(4, 4);
    chk_pv("r9", 8, 8, 0);
    drive_period(4, 4);
    chk_pv("r10", 9, 8, 1);

    waited = 0;
    while (lost !== 1'b1 && waited < 20) begin
      @(negedge clock_in);
      waited++;
    end
    chk_val("loss_lvl",    int'(lost), 1);
    chk_val("loss_lat",    cyc - rise_cyc, 13);
    chk_val("loss_locked", int'(locked), 0);
    chk_val("loss_pv",     pv_cnt, 9);

    @(posedge clock_in); #1;
    drive_period(4, 4);
    chk_val("r11_no_pv", pv_cnt, 9);
    chk_val("r11_lost",  int'(lost), 0);
    chk_val("r11_lock",  int'(locked), 0);
    drive_period(4, 4);
    chk_pv("r12", 10, 8, 0);
    drive_period(4, 4);
    chk_pv("r13", 11, 8, 1);

    repeat (2) begin @(posedge clock_in); #1; end
    #2;
    chk_val("pre_rst_period", int'(period_out), 8);
    chk_val("pre_rst_locked", int'(locked), 1);
    reset_n = 1'b0;
    #1;
    chk_val("mid_rst_period", int'(period_out), 0);
    chk_val("mid_rst_locked", int'(locked), 0);
    chk_val("mid_rst_lost",   int'(lost), 0);
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    repeat (3) begin @(posedge clock_in); #1; end

    drive_period(4, 4);
    chk_val("r15_tick_lat", last_tick_cyc - rise_cyc, 3);
    chk_val("r15_ticks",    tick_cnt, 14);
    chk_val("r15_no_pv",    pv_cnt, 11);
    drive_period(4, 4);
    chk_pv("r16", 12, 8, 0);
    drive_period(4, 4);
    chk_pv("r17", 13, 8, 1);
    chk_val("r17_locked_lvl", int'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
